// File: rtl/duck_round_ctrl.sv
// Purpose : round/duck sequencer for a light-gun duck game; counts shots, hits, score and rounds.
// Latency : one cycle from an input event to the registered state, duck_state and counter update.
// Backpressure: none; flew_away/duck_ded_done/trigger are sampled only in the states that use them.
// Option  : define DUCK_PERFECT_BONUS_EN to add a 10000-point bonus for a round with every duck hit.
module duck_round_ctrl #(
   parameter int SHOTS_PER_DUCK  = 3,
   parameter int DUCKS_PER_ROUND = 10,
   parameter int PASS_HITS       = 6,
   parameter int PAUSE_FRAMES    = 60
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic        start,
   input  logic        trigger,
   input  logic        hit,
   input  logic        flew_away,
   input  logic        duck_ded_done,
   output logic [2:0]  duck_state,
   output logic        new_round,
   output logic [1:0]  shots_left,
   output logic [3:0]  duck_index,
   output logic [9:0]  hit_mask,
   output logic [15:0] score,
   output logic [7:0]  round_num,
   output logic        game_over
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LAUNCH = 3'd1;
   localparam logic [2:0] S_FLY    = 3'd2;
   localparam logic [2:0] S_SHOT   = 3'd3;
   localparam logic [2:0] S_PAUSE  = 3'd4;
   localparam logic [2:0] S_TALLY  = 3'd5;
   localparam logic [2:0] S_OVER   = 3'd6;

   localparam logic [2:0] DS_HOLD = 3'b001;
   localparam logic [2:0] DS_FLY  = 3'b010;
   localparam logic [2:0] DS_SHOT = 3'b100;

   localparam logic [1:0] SHOTS_C = 2'(SHOTS_PER_DUCK);
   localparam logic [3:0] DUCKS_C = 4'(DUCKS_PER_ROUND);
   localparam logic [3:0] PASS_C  = 4'(PASS_HITS);

   // Pause counter only needs to reach PAUSE_FRAMES-1; the terminal edge wraps it.
   localparam int         CNT_W    = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAUSE_FRAMES - 1);

   logic [2:0]       r_state;
   logic [2:0]       w_state_nxt;
   logic [2:0]       r_duck_state;
   logic             r_new_round;
   logic [1:0]       r_shots_left;
   logic [3:0]       r_duck_index;
   logic [9:0]       r_hit_mask;
   logic [15:0]      r_score;
   logic [7:0]       r_round_num;
   logic             r_game_over;

   logic             r_trig_prev;
   logic             r_frame_meta;
   logic             r_frame_sync;
   logic             r_frame_prev;
   logic [CNT_W-1:0] r_pause_cnt;

   logic             w_start_go;
   logic             w_trig_edge;
   logic             w_shot_cnt;
   logic             w_shot_hit;
   logic             w_frame_edge;
   logic             w_pause_last;
   logic [3:0]       w_idx_inc;
   logic [3:0]       w_hit_pop;
   logic             w_tally_pass;
   logic [16:0]      w_score_add;
   logic [15:0]      w_score_hit;

`ifdef DUCK_PERFECT_BONUS_EN
   localparam logic [9:0] FULL_MASK = 10'((1 << DUCKS_PER_ROUND) - 1);
   logic             w_perfect;
   logic [16:0]      w_bonus_add;
   logic [15:0]      w_score_bonus;

   assign w_perfect     = (r_hit_mask & FULL_MASK) == FULL_MASK;
   assign w_bonus_add   = {1'b0, r_score} + 17'd10000;
   assign w_score_bonus = w_bonus_add[16] ? 16'hFFFF : w_bonus_add[15:0];
`endif

   function automatic logic [3:0] popcount10(input logic [9:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 10; i++) begin
         n = n + {3'd0, v[i]};
      end
      return n;
   endfunction

   function automatic logic [2:0] duck_cmd(input logic [2:0] st);
      logic [2:0] d;
      d = DS_HOLD;
      if (st == S_FLY) begin
         d = DS_FLY;
      end else if (st == S_SHOT) begin
         d = DS_SHOT;
      end
      return d;
   endfunction

   assign w_start_go   = ((r_state == S_IDLE) || (r_state == S_OVER)) && start;
   assign w_trig_edge  = trigger && !r_trig_prev;
   // flew_away takes priority over a shot in the same cycle, so it masks the edge.
   assign w_shot_cnt   = (r_state == S_FLY) && !flew_away && w_trig_edge && (r_shots_left != 2'd0);
   assign w_shot_hit   = w_shot_cnt && hit;
   assign w_frame_edge = r_frame_sync && !r_frame_prev;
   assign w_pause_last = (r_state == S_PAUSE) && w_frame_edge && (r_pause_cnt == CNT_LAST);
   assign w_idx_inc    = r_duck_index + 4'd1;
   assign w_hit_pop    = popcount10(r_hit_mask);
   assign w_tally_pass = (r_state == S_TALLY) && (w_hit_pop >= PASS_C);
   assign w_score_add  = {1'b0, r_score} + 17'd100;
   assign w_score_hit  = w_score_add[16] ? 16'hFFFF : w_score_add[15:0];

   // Next-state decode for the round sequencer.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_OVER: begin
            if (start) w_state_nxt = S_LAUNCH;
         end
         S_LAUNCH: w_state_nxt = S_FLY;
         S_FLY: begin
            if (flew_away) begin
               w_state_nxt = S_PAUSE;
            end else if (w_shot_hit) begin
               w_state_nxt = S_SHOT;
            end
         end
         S_SHOT: begin
            if (duck_ded_done) w_state_nxt = S_PAUSE;
         end
         S_PAUSE: begin
            if (w_pause_last) begin
               w_state_nxt = (w_idx_inc == DUCKS_C) ? S_TALLY : S_LAUNCH;
            end
         end
         S_TALLY: w_state_nxt = w_tally_pass ? S_LAUNCH : S_OVER;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register; duck_state and game_over are decoded from the next state so they move with it.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state      <= S_IDLE;
         r_duck_state <= DS_HOLD;
         r_game_over  <= 1'b0;
         r_new_round  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_duck_state <= duck_cmd(w_state_nxt);
         r_game_over  <= (w_state_nxt == S_OVER);
         r_new_round  <= w_start_go || w_tally_pass;
      end
   end

   // Trigger history and two-flop frame_clk synchronizer with rising-edge detect.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_trig_prev  <= 1'b0;
         r_frame_meta <= 1'b0;
         r_frame_sync <= 1'b0;
         r_frame_prev <= 1'b0;
      end else begin
         r_trig_prev  <= trigger;
         r_frame_meta <= frame_clk;
         r_frame_sync <= r_frame_meta;
         r_frame_prev <= r_frame_sync;
      end
   end

   // Frame-edge counter for the gap between ducks; idle at zero outside PAUSE.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_pause_cnt <= '0;
      end else if (r_state != S_PAUSE) begin
         r_pause_cnt <= '0;
      end else if (w_frame_edge) begin
         r_pause_cnt <= (r_pause_cnt == CNT_LAST) ? '0 : r_pause_cnt + 1'b1;
      end
   end

   // Shots remaining for the current duck.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_shots_left <= 2'd0;
      end else if (r_state == S_LAUNCH) begin
         r_shots_left <= SHOTS_C;
      end else if (w_shot_cnt) begin
         r_shots_left <= r_shots_left - 2'd1;
      end
   end

   // Per-round bookkeeping: duck index, hit mask and round number.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_duck_index <= 4'd0;
         r_hit_mask   <= 10'd0;
         r_round_num  <= 8'd0;
      end else if (w_start_go) begin
         r_duck_index <= 4'd0;
         r_hit_mask   <= 10'd0;
         r_round_num  <= 8'd0;
      end else if (w_tally_pass) begin
         r_duck_index <= 4'd0;
         r_hit_mask   <= 10'd0;
         r_round_num  <= r_round_num + 8'd1;
      end else begin
         if (w_pause_last) r_duck_index <= w_idx_inc;
         if (w_shot_hit)   r_hit_mask   <= r_hit_mask | (10'd1 << r_duck_index);
      end
   end

   // Saturating score: 100 per hit, optional perfect-round bonus at tally.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_score <= 16'd0;
      end else if (w_start_go) begin
         r_score <= 16'd0;
      end else if (w_shot_hit) begin
         r_score <= w_score_hit;
      end
`ifdef DUCK_PERFECT_BONUS_EN
      else if ((r_state == S_TALLY) && w_perfect) begin
         r_score <= w_score_bonus;
      end
`endif
   end

   assign duck_state = r_duck_state;
   assign new_round  = r_new_round;
   assign shots_left = r_shots_left;
   assign duck_index = r_duck_index;
   assign hit_mask   = r_hit_mask;
   assign score      = r_score;
   assign round_num  = r_round_num;
   assign game_over  = r_game_over;

endmodule

// File: tb/tb_duck_round_ctrl.sv
// Directed bench for duck_round_ctrl with a short pause (2 frame edges) to keep rounds quick.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
module tb_duck_round_ctrl;

   localparam int PF = 2;
`ifdef DUCK_PERFECT_BONUS_EN
   localparam int PERFECT_SCORE = 11000;
`else
   localparam int PERFECT_SCORE = 1000;
`endif

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        frame_clk = 1'b0;
   logic        start = 1'b0;
   logic        trigger = 1'b0;
   logic        hit = 1'b0;
   logic        flew_away = 1'b0;
   logic        duck_ded_done = 1'b0;
   logic [2:0]  duck_state;
   logic        new_round;
   logic [1:0]  shots_left;
   logic [3:0]  duck_index;
   logic [9:0]  hit_mask;
   logic [15:0] score;
   logic [7:0]  round_num;
   logic        game_over;

   int n_checks = 0;
   int n_errors = 0;
   int nr_cnt   = 0;

   duck_round_ctrl #(
      .SHOTS_PER_DUCK (3),
      .DUCKS_PER_ROUND(10),
      .PASS_HITS      (6),
      .PAUSE_FRAMES   (PF)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .frame_clk    (frame_clk),
      .start        (start),
      .trigger      (trigger),
      .hit          (hit),
      .flew_away    (flew_away),
      .duck_ded_done(duck_ded_done),
      .duck_state   (duck_state),
      .new_round    (new_round),
      .shots_left   (shots_left),
      .duck_index   (duck_index),
      .hit_mask     (hit_mask),
      .score        (score),
      .round_num    (round_num),
      .game_over    (game_over)
   );

   always #10 Clk = ~Clk;

   // Count cycles with new_round high, sampled mid-cycle.
   always @(negedge Clk) begin
      if (new_round === 1'b1) nr_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic frame_pulse();
      frame_clk = 1'b1;
      repeat (4) tick();
      frame_clk = 1'b0;
      repeat (4) tick();
   endtask

   task automatic pause_frames();
      repeat (PF) frame_pulse();
   endtask

   task automatic wait_fly(input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (duck_state == 3'b010) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk(tag, {31'd0, found}, 32'd1);
   endtask

   task automatic shoot(input logic h);
      trigger = 1'b1;
      hit     = h;
      tick();
      trigger = 1'b0;
      hit     = 1'b0;
      tick();
   endtask

   task automatic duck_hit();
      wait_fly("hit_wait_fly");
      shoot(1'b1);
      duck_ded_done = 1'b1;
      tick();
      duck_ded_done = 1'b0;
      pause_frames();
   endtask

   task automatic duck_miss();
      wait_fly("miss_wait_fly");
      flew_away = 1'b1;
      tick();
      flew_away = 1'b0;
      pause_frames();
   endtask

   initial begin
      int nr_base;

      // Reset state
      repeat (3) tick();
      chk("rst_duck_state", {29'd0, duck_state}, 32'd1);
      chk("rst_score", {16'd0, score}, 32'd0);
      chk("rst_shots", {30'd0, shots_left}, 32'd0);
      chk("rst_game_over", {31'd0, game_over}, 32'd0);
      chk("rst_new_round", {31'd0, new_round}, 32'd0);
      Reset = 1'b0;
      tick();

      // Start: LAUNCH with new_round, then FLY with full shots
      nr_base = nr_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("launch_new_round", {31'd0, new_round}, 32'd1);
      chk("launch_duck_state", {29'd0, duck_state}, 32'd1);
      tick();
      chk("fly_duck_state", {29'd0, duck_state}, 32'd2);
      chk("fly_shots", {30'd0, shots_left}, 32'd3);
      chk("fly_new_round_low", {31'd0, new_round}, 32'd0);
      chk("new_round_width", nr_cnt - nr_base, 32'd1);

      // Duck 0: hit on the first shot
      trigger = 1'b1;
      hit     = 1'b1;
      tick();
      trigger = 1'b0;
      hit     = 1'b0;
      chk("hit_duck_state", {29'd0, duck_state}, 32'd4);
      chk("hit_score", {16'd0, score}, 32'd100);
      chk("hit_mask0", {22'd0, hit_mask}, 32'd1);
      chk("hit_shots", {30'd0, shots_left}, 32'd2);
      tick();
      shoot(1'b1);  // ignored in SHOT
      chk("shot_ignore_shots", {30'd0, shots_left}, 32'd2);
      chk("shot_ignore_score", {16'd0, score}, 32'd100);
      duck_ded_done = 1'b1;
      tick();
      duck_ded_done = 1'b0;
      chk("ded_to_pause", {29'd0, duck_state}, 32'd1);
      pause_frames();
      wait_fly("d1_wait_fly");
      chk("d1_index", {28'd0, duck_index}, 32'd1);
      chk("d1_shots", {30'd0, shots_left}, 32'd3);

      // Duck 1: three misses exhaust shots, a fourth hit edge is ignored
      repeat (3) shoot(1'b0);
      chk("d1_shots_empty", {30'd0, shots_left}, 32'd0);
      shoot(1'b1);
      chk("d1_empty_state", {29'd0, duck_state}, 32'd2);
      chk("d1_empty_score", {16'd0, score}, 32'd100);
      chk("d1_empty_mask", {22'd0, hit_mask}, 32'd1);
      flew_away = 1'b1;
      tick();
      flew_away = 1'b0;
      chk("d1_flew_state", {29'd0, duck_state}, 32'd1);
      pause_frames();

      // Duck 2: flew_away beats a simultaneous hit edge
      wait_fly("d2_wait_fly");
      chk("d2_index", {28'd0, duck_index}, 32'd2);
      trigger   = 1'b1;
      hit       = 1'b1;
      flew_away = 1'b1;
      tick();
      trigger   = 1'b0;
      hit       = 1'b0;
      flew_away = 1'b0;
      chk("d2_race_state", {29'd0, duck_state}, 32'd1);
      chk("d2_race_score", {16'd0, score}, 32'd100);
      chk("d2_race_mask", {22'd0, hit_mask}, 32'd1);
      chk("d2_race_shots", {30'd0, shots_left}, 32'd3);
      pause_frames();

      // Ducks 3..9: hit 3..7, miss 8..9 -> 6 hits, pass
      for (int d = 3; d < 10; d++) begin
         if (d == 9) chk("r1_mask_pre", {22'd0, hit_mask}, 32'h0F9);
         if (d <= 7) duck_hit();
         else duck_miss();
      end
      nr_base = nr_cnt;
      wait_fly("r2_wait_fly");
      chk("r2_round_num", {24'd0, round_num}, 32'd1);
      chk("r2_mask_clear", {22'd0, hit_mask}, 32'd0);
      chk("r2_index_clear", {28'd0, duck_index}, 32'd0);
      chk("r2_score", {16'd0, score}, 32'd600);

      // Round 2: 5 hits -> OVER
      for (int d = 0; d < 10; d++) begin
         if (d < 5) duck_hit();
         else duck_miss();
      end
      chk("over_flag", {31'd0, game_over}, 32'd1);
      chk("over_duck_state", {29'd0, duck_state}, 32'd1);
      chk("over_score", {16'd0, score}, 32'd1100);
      chk("over_round_num", {24'd0, round_num}, 32'd1);

      // Restart from OVER clears everything
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_new_round", {31'd0, new_round}, 32'd1);
      chk("restart_game_over", {31'd0, game_over}, 32'd0);
      chk("restart_score", {16'd0, score}, 32'd0);
      chk("restart_round_num", {24'd0, round_num}, 32'd0);

      // Perfect round
      for (int d = 0; d < 10; d++) duck_hit();
      wait_fly("perf_wait_fly");
      chk("perf_score", {16'd0, score}, PERFECT_SCORE);
      chk("perf_round_num", {24'd0, round_num}, 32'd1);
      chk("perf_mask_clear", {22'd0, hit_mask}, 32'd0);

      // Reset in the middle of PAUSE
      shoot(1'b1);
      duck_ded_done = 1'b1;
      tick();
      duck_ded_done = 1'b0;
      chk("pre_rst_score", {16'd0, score}, PERFECT_SCORE + 100);
      frame_pulse();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("midrst_duck_state", {29'd0, duck_state}, 32'd1);
      chk("midrst_score", {16'd0, score}, 32'd0);
      chk("midrst_shots", {30'd0, shots_left}, 32'd0);
      chk("midrst_mask", {22'd0, hit_mask}, 32'd0);
      chk("midrst_round", {24'd0, round_num}, 32'd0);
      pause_frames();
      chk("idle_hold_state", {29'd0, duck_state}, 32'd1);
      chk("idle_hold_index", {28'd0, duck_index}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/duck_round_ctrl.md
DUCK_ROUND_CTRL -- requirements
Module: duck_round_ctrl

Interface
REQ-001 SHALL have parameter SHOTS_PER_DUCK, default 3, shots allowed per duck (1..3).
REQ-002 SHALL have parameter DUCKS_PER_ROUND, default 10, ducks launched per round (1..10).
REQ-003 SHALL have parameter PASS_HITS, default 6, minimum hits to advance to the next round.
REQ-004 SHALL have parameter PAUSE_FRAMES, default 60, frame_clk rising edges between ducks.
REQ-005 SHALL have port Clk  in  1  system clock (50 MHz).
REQ-006 SHALL have port Reset  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port frame_clk  in  1  ~60 Hz frame strobe, asynchronous level.
REQ-008 SHALL have port start  in  1  level; begins a game from IDLE or OVER.
REQ-009 SHALL have port trigger  in  1  debounced gun trigger level.
REQ-010 SHALL have port hit  in  1  crosshair-on-duck flag, valid in the same cycle as trigger.
REQ-011 SHALL have port flew_away  in  1  escape pulse from the duck block.
REQ-012 SHALL have port duck_ded_done  in  1  fall-complete pulse from the duck block.
REQ-013 SHALL have port duck_state  out  3  one-hot duck command: 001 hold/reset, 010 fly, 100 shot.
REQ-014 SHALL have port new_round  out  1  one-cycle pulse at round start.
REQ-015 SHALL have ports shots_left (out, 2), duck_index (out, 4), hit_mask (out, 10), score (out, 16), round_num (out, 8) and game_over (out, 1).

Function
REQ-016 States and outputs:
- IDLE: duck_state=001.
- LAUNCH: duck_state=001, lasts one cycle.
- FLY: duck_state=010.
- SHOT: duck_state=100.
- PAUSE: duck_state=001.
- TALLY: duck_state=001, lasts one cycle.
- OVER: duck_state=001, game_over=1.
REQ-017 IDLE or OVER with start=1 SHALL go to LAUNCH and clear score, hit_mask, duck_index and round_num to 0; new_round SHALL pulse in that cycle.
REQ-018 LAUNCH SHALL load shots_left=SHOTS_PER_DUCK and go to FLY on the next cycle.
REQ-019 Trigger edge = trigger high this cycle and low the previous cycle; only edges seen in FLY with shots_left>0 SHALL count.
REQ-020 A counted edge SHALL decrement shots_left by 1.
REQ-021 A counted edge with hit=1 SHALL also, in the same cycle:
- go to SHOT;
- set hit_mask[duck_index];
- add 100 to score, saturating at 16'hFFFF.
REQ-022 In FLY with shots_left=0, hit=1 and edges SHALL be ignored; the duck keeps flying until flew_away.
REQ-023 In FLY, flew_away=1 SHALL go to PAUSE as a miss.
REQ-024 If flew_away and a counted edge occur in the same cycle, flew_away SHALL win: shots_left, score and hit_mask stay unchanged.
REQ-025 In SHOT, duck_ded_done=1 SHALL go to PAUSE; trigger SHALL be ignored.
REQ-026 In PAUSE:
- Count PAUSE_FRAMES frame_clk rising edges; frame_clk is synchronized with two flops first.
- On the final edge, increment duck_index.
- If the new duck_index equals DUCKS_PER_ROUND, go to TALLY; otherwise go to LAUNCH.
REQ-027 In TALLY, popcount(hit_mask) >= PASS_HITS SHALL:
- increment round_num, wrapping 255->0;
- clear hit_mask and duck_index;
- pulse new_round;
- go to LAUNCH.
Otherwise TALLY SHALL go to OVER.
REQ-028 duck_state SHALL be registered and change in the same cycle as the state.
REQ-029 hit, flew_away and duck_ded_done SHALL be ignored in any state not named above for them.

Reset
REQ-030 Reset SHALL force IDLE from any state, including mid-FLY and mid-PAUSE.
REQ-031 On Reset, all outputs and counters SHALL be 0, except duck_state=001.
REQ-032 The trigger-edge history register and the frame_clk synchronizer SHALL clear on Reset.

Configuration
REQ-033 Macro DUCK_PERFECT_BONUS_EN defined: a TALLY with all DUCKS_PER_ROUND bits of hit_mask set SHALL add 10000 to score, saturating, before advancing.
REQ-034 Macro DUCK_PERFECT_BONUS_EN undefined: no bonus logic SHALL exist, and a perfect round scores only the per-hit points.

Verification
REQ-035 start pulse -> LAUNCH then FLY; duck_state 001->010; shots_left=3; new_round high for exactly 1 cycle.
REQ-036 In FLY, trigger edge with hit=1 -> duck_state=100, score=100, hit_mask=10'b0000000001, shots_left=2.
REQ-037 Three trigger edges with hit=0, then a 4th edge with hit=1 -> shots_left=0, score=0, state stays FLY until flew_away, then PAUSE.
REQ-038 flew_away and a hit edge in the same cycle -> PAUSE; score=0; hit_mask bit clear; shots_left=3.
REQ-039 10 ducks, 6 hit -> round_num=1 and new_round pulse; 10 ducks, 5 hit -> OVER, game_over=1.
REQ-040 Reset asserted mid-PAUSE with score=600 -> next cycle IDLE, score=0, duck_state=001; with DUCK_PERFECT_BONUS_EN, 10/10 hits -> score=11000.
